mem_access_unit: RTL and testbench

//  MEM-stage initiator for the word-addressed data memory. Takes load/store requests from the
//  EX/MEM register and drives Address/Writedata/MemRead/MemWrite. Captures Readdata, extracts and

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_lane_align.sv | 53 +++++
 rtl/mem_access_unit.sv | 146 ++++++++++++++
 tb/tb_mem_access_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data memory initiator: access sizes and FSM states.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_ISSUE   = 3'd1,
        RD_CAPTURE = 3'd2,
        WR_ISSUE   = 3'd3,
        RELEASE    = 3'd4
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a little-endian 32-bit word: load extract/extend and store merge.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  byte_off,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_data
);

    logic [4:0]  lane_shift;
    logic [31:0] shifted;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] lane_mask;
    logic [31:0] lane_ins;

    always_comb begin
        lane_shift = {byte_off, 3'b000};
        shifted    = rdata >> lane_shift;
        lane_b     = shifted[7:0];
        lane_h     = byte_off[1] ? rdata[31:16] : rdata[15:0];
        load_data  = rdata;
        lane_mask  = 32'h0000_0000;
        lane_ins   = 32'h0000_0000;

        case (size)
            SZ_BYTE: begin
                load_data = {{24{sign_ext & lane_b[7]}}, lane_b};
                lane_mask = 32'h0000_00FF << lane_shift;
                lane_ins  = {24'h00_0000, store_data[7:0]} << lane_shift;
            end
            SZ_HALF: begin
                // Half accesses ignore byte_off[0]; alignment is checked upstream.
                load_data = {{16{sign_ext & lane_h[15]}}, lane_h};
                lane_mask = byte_off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                lane_ins  = byte_off[1] ? {store_data[15:0], 16'h0000}
                                        : {16'h0000, store_data[15:0]};
            end
            default: begin
                load_data = rdata;
            end
        endcase

        merged_data = (size == SZ_BYTE || size == SZ_HALF)
                    ? ((rdata & ~lane_mask) | lane_ins)
                    : store_data;
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: sequences strobed reads/writes to word memory, with sub-word RMW stores.
//
// state      | meaning
// IDLE       | waiting for a load/store request; Stall follows the request
// RD_ISSUE   | MemRead held high, READ_LAT-cycle down-counter running
// RD_CAPTURE | MemRead low; Readdata extracted (load) or merged (sub-word store)
// WR_ISSUE   | MemWrite high for one cycle with the final word
// RELEASE    | strobes low, Done pulse (AccessFault if rejected), pipeline released
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 65,
    parameter int READ_LAT  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ReqValid,
    input  logic              IsLoad,
    input  logic              IsStore,
    input  logic [1:0]        Size,
    input  logic              SignExt,
    input  logic [ADDR_W-1:0] ByteAddr,
    input  logic [DATA_W-1:0] StoreData,
    output logic              Stall,
    output logic              Done,
    output logic [DATA_W-1:0] LoadData,
    output logic              AccessFault,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] Writedata,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [DATA_W-1:0] Readdata
);

    localparam int CNT_W = (READ_LAT < 2) ? 1 : $clog2(READ_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LAT - 1);

    state_t state, state_nxt;

    logic              req;
    logic              is_word;
    logic              fault_now;
    logic [ADDR_W-1:0] word_idx;
    logic [CNT_W-1:0]  lat_cnt;

    logic [1:0]        addr_lo_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic              is_load_q;
    logic [DATA_W-1:0] store_q;

    logic [DATA_W-1:0] ext_load;
    logic [DATA_W-1:0] merged;

    mem_lane_align u_align (
        .rdata       (Readdata),
        .byte_off    (addr_lo_q),
        .size        (size_q),
        .sign_ext    (sign_q),
        .store_data  (store_q),
        .load_data   (ext_load),
        .merged_data (merged)
    );

    always_comb begin
        req       = ReqValid & (IsLoad | IsStore);
        is_word   = (Size != SZ_BYTE) && (Size != SZ_HALF);
        word_idx  = ByteAddr >> 2;
        fault_now = (IsLoad & IsStore)
                  | ((Size == SZ_HALF) & ByteAddr[0])
                  | (is_word & (ByteAddr[1:0] != 2'b00))
                  | (word_idx >= ADDR_W'(MEM_WORDS));
        Stall     = ((state == IDLE) & req)
                  | (state == RD_ISSUE) | (state == RD_CAPTURE) | (state == WR_ISSUE);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (fault_now)
                        state_nxt = RELEASE;
                    else if (IsLoad || !is_word)
                        state_nxt = RD_ISSUE;
                    else
                        state_nxt = WR_ISSUE;
                end
            end
            RD_ISSUE:   if (lat_cnt == '0) state_nxt = RD_CAPTURE;
            RD_CAPTURE: state_nxt = is_load_q ? RELEASE : WR_ISSUE;
            WR_ISSUE:   state_nxt = RELEASE;
            RELEASE:    state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            MemRead     <= 1'b0;
            MemWrite    <= 1'b0;
            Done        <= 1'b0;
            AccessFault <= 1'b0;
            Address     <= '0;
            Writedata   <= '0;
            LoadData    <= '0;
            lat_cnt     <= '0;
            addr_lo_q   <= 2'b00;
            size_q      <= SZ_BYTE;
            sign_q      <= 1'b0;
            is_load_q   <= 1'b0;
            store_q     <= '0;
        end else begin
            state       <= state_nxt;
            MemRead     <= (state_nxt == RD_ISSUE);
            MemWrite    <= (state_nxt == WR_ISSUE);
            Done        <= (state_nxt == RELEASE);
            // Only a rejected request goes straight from IDLE to RELEASE.
            AccessFault <= (state == IDLE) && (state_nxt == RELEASE);

            if (state == IDLE)
                lat_cnt <= LAT_LOAD;
            else if (state == RD_ISSUE && lat_cnt != '0)
                lat_cnt <= lat_cnt - 1'b1;

            if (state == IDLE && req) begin
                Address   <= word_idx;
                addr_lo_q <= ByteAddr[1:0];
                size_q    <= Size;
                sign_q    <= SignExt;
                is_load_q <= IsLoad;
                store_q   <= StoreData;
            end

            if (state_nxt == WR_ISSUE)
                Writedata <= (state == IDLE) ? StoreData : merged;

            if (state == RD_CAPTURE && is_load_q)
                LoadData <= ext_load;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized loads/stores
// checked against a byte-array memory model.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int MEM_WORDS = 65;
    localparam int READ_LAT  = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        ReqValid, IsLoad, IsStore, SignExt;
    logic [1:0]  Size;
    logic [31:0] ByteAddr, StoreData;
    logic        Stall, Done, AccessFault, MemRead, MemWrite;
    logic [31:0] LoadData, Address, Writedata, Readdata;

    always #5 clk = ~clk;

    mem_access_unit #(
        .ADDR_W(32), .DATA_W(32), .MEM_WORDS(MEM_WORDS), .READ_LAT(READ_LAT)
    ) dut (
        .clk(clk), .reset(reset), .ReqValid(ReqValid), .IsLoad(IsLoad), .IsStore(IsStore),
        .Size(Size), .SignExt(SignExt), .ByteAddr(ByteAddr), .StoreData(StoreData),
        .Stall(Stall), .Done(Done), .LoadData(LoadData), .AccessFault(AccessFault),
        .Address(Address), .Writedata(Writedata), .MemRead(MemRead), .MemWrite(MemWrite),
        .Readdata(Readdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [31:0] init_word(int i);
        case (i)
            1:       return 32'd32;
            5:       return 32'd100;
            17:      return 32'd200;
            default: return (32'(i) * 32'h0103_0507) ^ 32'hA5C3_0F18;
        endcase
    endfunction

    // Memory the DUT talks to: reacts to strobes at the clock edge.
    logic [31:0] mem [0:127];
    logic        load_mem;

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_word(i);
            Readdata <= 32'h0;
        end else begin
            if (MemRead)  Readdata <= mem[Address[6:0]];
            if (MemWrite) mem[Address[6:0]] <= Writedata;
        end
    end

    // Strobe monitor
    int          rd_rises = 0, wr_rises = 0, rd_hi = 0, both_hi = 0, nogap = 0;
    logic        prev_rd = 1'b0, prev_wr = 1'b0;
    logic [31:0] rd_addr = 32'h0, wr_addr = 32'h0, wr_data = 32'h0;

    always @(negedge clk) begin
        if (MemRead && !prev_rd) begin rd_rises++; rd_addr = Address; end
        if (MemWrite && !prev_wr) begin wr_rises++; wr_addr = Address; wr_data = Writedata; end
        if (MemRead) rd_hi++;
        if (MemRead && MemWrite) both_hi++;
        if ((MemRead && prev_wr) || (MemWrite && prev_rd)) nogap++;
        prev_rd = MemRead;
        prev_wr = MemWrite;
    end

    // Reference model: memory as a flat little-endian byte array.
    logic [7:0] ref_bytes [0:511];

    function automatic logic [31:0] ref_word(int idx);
        return {ref_bytes[idx*4+3], ref_bytes[idx*4+2], ref_bytes[idx*4+1], ref_bytes[idx*4]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic ld, input logic st, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] ld_obs);
        int          idx, base, exp_lat, exp_rd, exp_wr, lat, stall_cyc, r0, w0, h0;
        logic        exp_fault, got_done;
        logic [31:0] exp_ld, exp_wd;
        logic [7:0]  b;
        logic [15:0] h;

        idx       = int'(a >> 2);
        base      = idx * 4;
        exp_fault = (ld && st) || (sz == SZ_HALF && a[0]) || (sz == SZ_WORD && a[1:0] != 2'b00)
                  || (idx >= MEM_WORDS);
        exp_ld = 32'h0;
        exp_wd = 32'h0;
        exp_rd = 0;
        exp_wr = 0;
        if (exp_fault) begin
            exp_lat = 1;
        end else if (ld) begin
            exp_lat = 2 + READ_LAT;
            exp_rd  = 1;
            if (sz == SZ_BYTE) begin
                b = ref_bytes[base + int'(a[1:0])];
                exp_ld = (sx && b >= 8'd128) ? 32'(int'(b) - 256) : 32'(b);
            end else if (sz == SZ_HALF) begin
                h = {ref_bytes[base + (a[1] ? 3 : 1)], ref_bytes[base + (a[1] ? 2 : 0)]};
                exp_ld = (sx && h >= 16'd32768) ? 32'(int'(h) - 65536) : 32'(h);
            end else begin
                exp_ld = ref_word(idx);
            end
        end else begin
            exp_wr = 1;
            if (sz == SZ_WORD) begin
                exp_lat = 2;
                for (int k = 0; k < 4; k++) ref_bytes[base + k] = d[8*k +: 8];
            end else begin
                exp_lat = 3 + READ_LAT;
                exp_rd  = 1;
                if (sz == SZ_BYTE) begin
                    ref_bytes[base + int'(a[1:0])] = d[7:0];
                end else begin
                    ref_bytes[base + (a[1] ? 2 : 0)] = d[7:0];
                    ref_bytes[base + (a[1] ? 3 : 1)] = d[15:8];
                end
            end
            exp_wd = ref_word(idx);
        end

        @(negedge clk);
        ReqValid = 1'b1; IsLoad = ld; IsStore = st; Size = sz; SignExt = sx;
        ByteAddr = a; StoreData = d;
        r0 = rd_rises; w0 = wr_rises; h0 = rd_hi;
        #1 chk({tag, "_stall_req"}, 32'(Stall), 32'd1);
        @(posedge clk);
        #1 ReqValid = 1'b0; IsLoad = 1'b0; IsStore = 1'b0;

        lat = 0; stall_cyc = 0; got_done = 1'b0;
        for (int k = 1; k <= 20 && !got_done; k++) begin
            @(negedge clk);
            if (Done) begin got_done = 1'b1; lat = k; end
            else if (Stall) stall_cyc++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_stall_cycles"}, 32'(stall_cyc), 32'(exp_lat - 1));
        chk({tag, "_stall_done"}, 32'(Stall), 32'd0);
        chk({tag, "_fault"}, 32'(AccessFault), 32'(exp_fault));
        ld_obs = LoadData;
        if (ld && !exp_fault) chk({tag, "_loaddata"}, LoadData, exp_ld);

        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 32'(Done), 32'd0);
        chk({tag, "_rd_pulses"}, 32'(rd_rises - r0), 32'(exp_rd));
        chk({tag, "_wr_pulses"}, 32'(wr_rises - w0), 32'(exp_wr));
        if (exp_rd != 0) begin
            chk({tag, "_rd_len"}, 32'(rd_hi - h0), 32'(READ_LAT));
            chk({tag, "_rd_addr"}, rd_addr, 32'(idx));
        end
        if (exp_wr != 0) begin
            chk({tag, "_wr_addr"}, wr_addr, 32'(idx));
            chk({tag, "_wr_data"}, wr_data, exp_wd);
        end
    endtask

    logic [31:0] obs;
    logic [31:0] ra;
    int          kind;

    initial begin
        reset = 1'b1; load_mem = 1'b1;
        ReqValid = 1'b0; IsLoad = 1'b0; IsStore = 1'b0; Size = SZ_BYTE; SignExt = 1'b0;
        ByteAddr = 32'h0; StoreData = 32'h0;
        for (int i = 0; i < 128; i++)
            for (int k = 0; k < 4; k++) ref_bytes[i*4 + k] = init_word(i) >> (8*k);

        repeat (3) @(negedge clk);
        load_mem = 1'b0;
        chk("rst_memread", 32'(MemRead), 32'd0);
        chk("rst_memwrite", 32'(MemWrite), 32'd0);
        chk("rst_address", Address, 32'h0);
        chk("rst_writedata", Writedata, 32'h0);
        chk("rst_loaddata", LoadData, 32'h0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_fault", 32'(AccessFault), 32'd0);
        chk("rst_stall", 32'(Stall), 32'd0);
        reset = 1'b0;

        do_op("t1", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0, obs);
        chk("t1_value", obs, 32'd100);

        do_op("t2_st", 1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h45, 32'hAB, obs);
        do_op("t2_ld", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h44, 32'h0, obs);
        chk("t2_value", obs, 32'h0000_ABC8);

        do_op("t3_bs", 1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h45, 32'h0, obs);
        chk("t3_bs_value", obs, 32'hFFFF_FFAB);
        do_op("t3_bz", 1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h45, 32'h0, obs);
        chk("t3_bz_value", obs, 32'h0000_00AB);
        do_op("t3_hs", 1'b1, 1'b0, SZ_HALF, 1'b1, 32'h44, 32'h0, obs);
        chk("t3_hs_value", obs, 32'hFFFF_ABC8);

        do_op("t4_mis", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0, obs);
        do_op("t4_oor", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h104, 32'h0, obs);
        do_op("t4_ldst", 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h0, obs);

        do_op("t5_a", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h04, 32'h0, obs);
        chk("t5_a_value", obs, 32'd32);
        do_op("t5_b", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0, obs);
        chk("t5_b_value", obs, 32'd100);

        // Reset while the write strobe is up: the write lands, the access is dropped.
        @(negedge clk);
        ReqValid = 1'b1; IsLoad = 1'b0; IsStore = 1'b1; Size = SZ_WORD; SignExt = 1'b0;
        ByteAddr = 32'h08; StoreData = 32'h1234_5678;
        @(posedge clk);
        #1 ReqValid = 1'b0; IsStore = 1'b0;
        @(negedge clk);
        chk("t6_wr_issue", 32'(MemWrite), 32'd1);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) ref_bytes[8 + k] = 8'(32'h1234_5678 >> (8*k));
        @(negedge clk);
        chk("t6_memwrite", 32'(MemWrite), 32'd0);
        chk("t6_stall", 32'(Stall), 32'd0);
        chk("t6_done", 32'(Done), 32'd0);
        reset = 1'b0;
        do_op("t6_ld", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0, obs);
        chk("t6_value", obs, 32'h1234_5678);

        // Request with neither load nor store is ignored.
        @(negedge clk);
        ReqValid = 1'b1; IsLoad = 1'b0; IsStore = 1'b0;
        #1 chk("ign_stall", 32'(Stall), 32'd0);
        repeat (2) @(negedge clk);
        chk("ign_done", 32'(Done), 32'd0);
        chk("ign_memread", 32'(MemRead), 32'd0);
        ReqValid = 1'b0;

        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 9);
            ra = ($urandom_range(0, 7) == 0) ? 32'h104 + 32'($urandom_range(0, 11))
                                             : 32'($urandom_range(0, 259));
            do_op("rnd", kind == 0 || kind >= 6, kind <= 5, 2'($urandom_range(0, 2)),
                  1'($urandom_range(0, 1)), ra, $urandom, obs);
        end

        for (int i = 0; i < 128; i++) chk("final_mem", mem[i], ref_word(i));
        chk("both_strobes", 32'(both_hi), 32'd0);
        chk("strobe_gap", 32'(nogap), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
